// File: rtl/poly_root_search.sv
// ---------------------------------------------------------------------------
// poly_root_search
//
// Inverse of the cubic evaluator. This block takes a signed 19-bit target R
// and searches for the signed 4-bit X in [-8, 7] where
//     P(X) = A3*X^3 + A2*X^2 + A1*X + A0 == R.
// Candidates are tried in order from -8 up to 7. Each candidate is evaluated
// by Horner's rule on one shared multiply-add, so one candidate costs
// 3 EVAL cycles plus 1 CHECK cycle.
//
// Optional build macro: ROOT_COUNT_EN
//   When it is defined, the block always scans all 16 candidates and adds the
//   NROOTS output, which gives the number of matching candidates.
//
// Ports:
//   CLK    in   rising-edge clock
//   RST    in   synchronous reset, active-high, has priority over START
//   START  in   request a search; sampled only in IDLE
//   R      in   signed 19-bit target, captured on the accepted START edge
//   BUSY   out  high while in EVAL or CHECK
//   DONE   out  one-cycle pulse when a search ends
//   FOUND  out  a match exists; valid from DONE until the next accepted START
//   X      out  signed root when FOUND=1, otherwise 0
//   NROOTS out  (ROOT_COUNT_EN only) number of matches, 0..16
// ---------------------------------------------------------------------------
module poly_root_search #(
    parameter logic signed [7:0] A3 = 8'sd2,
    parameter logic signed [7:0] A2 = -8'sd3,
    parameter logic signed [7:0] A1 = 8'sd5,
    parameter logic signed [7:0] A0 = 8'sd7
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic signed [18:0] R,
    output logic               BUSY,
    output logic               DONE,
    output logic               FOUND,
    output logic signed [3:0]  X
`ifdef ROOT_COUNT_EN
    ,
    output logic [4:0]         NROOTS
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EVAL  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic signed [23:0] A3_EXT = 24'(A3);

    logic [1:0]         state_reg;
    logic signed [18:0] r_reg;
    logic signed [3:0]  cand_reg;
    logic signed [23:0] acc_reg;
    logic [1:0]         step_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               found_reg;
    logic signed [3:0]  x_reg;
`ifdef ROOT_COUNT_EN
    logic [4:0]         count_reg;
    logic [4:0]         nroots_reg;
    logic [4:0]         count_next;
`endif

    // Horner step: the coefficient that is added depends on how far the
    // evaluation has progressed (A2, then A1, then A0).
    logic signed [23:0] coef_next;
    logic signed [23:0] cand_ext;
    logic signed [23:0] mac_next;
    logic               match;

    always_comb begin
        coef_next = 24'(A0);
        case (step_reg)
            2'd0:    coef_next = 24'(A2);
            2'd1:    coef_next = 24'(A1);
            default: coef_next = 24'(A0);
        endcase
    end

    assign cand_ext = 24'(cand_reg);
    // |P| stays far below 2^23, so the truncation to 24 bits never loses information.
    assign mac_next = acc_reg * cand_ext + coef_next;
    assign match    = (acc_reg == 24'(r_reg));

`ifdef ROOT_COUNT_EN
    assign count_next = count_reg + {4'd0, match};
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= ST_IDLE;
            r_reg      <= '0;
            cand_reg   <= '0;
            acc_reg    <= '0;
            step_reg   <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            found_reg  <= 1'b0;
            x_reg      <= '0;
`ifdef ROOT_COUNT_EN
            count_reg  <= '0;
            nroots_reg <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (START) begin
                        r_reg     <= R;
                        cand_reg  <= -4'sd8;
                        acc_reg   <= A3_EXT;
                        step_reg  <= 2'd0;
                        busy_reg  <= 1'b1;
                        found_reg <= 1'b0;
                        x_reg     <= '0;
`ifdef ROOT_COUNT_EN
                        count_reg <= '0;
`endif
                        state_reg <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    acc_reg <= mac_next;
                    if (step_reg == 2'd2) begin
                        step_reg  <= 2'd0;
                        state_reg <= ST_CHECK;
                    end else begin
                        step_reg <= step_reg + 2'd1;
                    end
                end
                ST_CHECK: begin
`ifdef ROOT_COUNT_EN
                    // The full range is always scanned. Only the first match
                    // is latched as the root.
                    count_reg <= count_next;
                    if (match && !found_reg) begin
                        found_reg <= 1'b1;
                        x_reg     <= cand_reg;
                    end
                    if (cand_reg == 4'sd7) begin
                        nroots_reg <= count_next;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= ST_DONE;
                    end else begin
                        cand_reg  <= cand_reg + 4'sd1;
                        acc_reg   <= A3_EXT;
                        step_reg  <= 2'd0;
                        state_reg <= ST_EVAL;
                    end
`else
                    if (match) begin
                        found_reg <= 1'b1;
                        x_reg     <= cand_reg;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (cand_reg == 4'sd7) begin
                        // Last candidate failed: report no root. cand does not wrap.
                        found_reg <= 1'b0;
                        x_reg     <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        cand_reg  <= cand_reg + 4'sd1;
                        acc_reg   <= A3_EXT;
                        step_reg  <= 2'd0;
                        state_reg <= ST_EVAL;
                    end
`endif
                end
                default: begin
                    // ST_DONE: this state lasts one cycle and ignores START.
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY  = busy_reg;
    assign DONE  = done_reg;
    assign FOUND = found_reg;
    assign X     = x_reg;
`ifdef ROOT_COUNT_EN
    assign NROOTS = nroots_reg;
`endif

endmodule

// File: tb/tb_poly_root_search.sv
// ---------------------------------------------------------------------------
// tb_poly_root_search
//
// Scoreboard bench for poly_root_search. Each search that is issued pushes
// the expected result into a queue. The expected result is computed by
// brute-force evaluation of the polynomial for every X. An independent
// monitor pops and compares an entry whenever DONE is seen.
// With ROOT_COUNT_EN defined, the bench uses P = X^2 and also checks NROOTS.
// ---------------------------------------------------------------------------
module tb_poly_root_search;

`ifdef ROOT_COUNT_EN
    localparam int CA3 = 0, CA2 = 1, CA1 = 0, CA0 = 0;
`else
    localparam int CA3 = 2, CA2 = -3, CA1 = 5, CA0 = 7;
`endif

    logic               CLK = 1'b0;
    logic               RST;
    logic               START;
    logic signed [18:0] R;
    logic               BUSY, DONE, FOUND;
    logic signed [3:0]  X;
`ifdef ROOT_COUNT_EN
    logic [4:0]         NROOTS;
`endif

    poly_root_search #(
        .A3(8'(CA3)), .A2(8'(CA2)), .A1(8'(CA1)), .A0(8'(CA0))
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .R(R),
        .BUSY(BUSY), .DONE(DONE), .FOUND(FOUND), .X(X)
`ifdef ROOT_COUNT_EN
        , .NROOTS(NROOTS)
`endif
    );

    always #5 CLK = ~CLK;

    // Number of rising edges seen so far. The bench reads it at the negedge.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int r;
        int found;
        int x;
        int lat;
        int nroots;
        int k;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    function automatic int p_of(int x);
        return CA3 * x * x * x + CA2 * x * x + CA1 * x + CA0;
    endfunction

    // Reference model: evaluate every candidate, keep the first match, count all.
    function automatic exp_t model(int r);
        exp_t e;
        e.found = 0; e.x = 0; e.nroots = 0; e.r = r; e.k = 0;
        for (int xi = -8; xi <= 7; xi++) begin
            if (p_of(xi) == r) begin
                if (e.found == 0) begin
                    e.found = 1;
                    e.x = xi;
                end
                e.nroots++;
            end
        end
`ifdef ROOT_COUNT_EN
        e.lat = 64;
`else
        e.lat = e.found ? 4 * (e.x + 9) : 64;
`endif
        return e;
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding search.
    always @(negedge CLK) begin
        if (!RST && DONE) begin
            int xs;
            done_seen++;
            xs = int'(X);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got DONE=1, expected no DONE (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("found", int'(FOUND), e.found);
                check("x", xs, e.x);
                check("latency", cyc - e.k, e.lat);
                check("busy_at_done", int'(BUSY), 0);
`ifdef ROOT_COUNT_EN
                check("nroots", int'(NROOTS), e.nroots);
`endif
                $display("result R=%0d found=%0d X=%0d latency=%0d (expected found=%0d X=%0d latency=%0d)",
                         e.r, FOUND, xs, cyc - e.k, e.found, e.x, e.lat);
            end
        end
    end

    // Issue one search. Optionally pulse START with another R in the middle.
    task automatic run_search(int r, bit pulse_mid, int mid_r);
        exp_t e;
        int n;
        bit got;
        @(negedge CLK);
        e = model(r);
        e.k = cyc + 1;
        n = done_seen;
        sb.push_back(e);
        START = 1'b1;
        R = 19'(r);
        @(negedge CLK);
        START = 1'b0;
        check("start_clears_found", int'(FOUND), 0);
        check("start_clears_x", int'(X), 0);
        check("busy_after_start", int'(BUSY), 1);
        if (pulse_mid) begin
            repeat (3) @(negedge CLK);
            START = 1'b1;
            R = 19'(mid_r);
            @(negedge CLK);
            START = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK);
            if (done_seen != n) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no DONE, expected DONE for R=%0d", r);
            sb.delete();
        end else begin
            @(negedge CLK);
            check("found_hold", int'(FOUND), e.found);
            check("x_hold", int'(X), e.x);
            check("done_is_pulse", int'(DONE), 0);
        end
    endtask

    task automatic abort_search(int r);
        int k;
        int n;
        @(negedge CLK);
        k = cyc + 1;
        n = done_seen;
        START = 1'b1;
        R = 19'(r);
        @(negedge CLK);
        START = 1'b0;
        while (cyc < k + 9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_busy", int'(BUSY), 0);
        check("abort_found", int'(FOUND), 0);
        repeat (70) @(negedge CLK);
        check("no_done_after_abort", done_seen - n, 0);
        $display("abort R=%0d reset at edge k+10, DONE pulses afterwards=%0d", r, done_seen - n);
    endtask

    initial begin
        RST = 1'b1;
        START = 1'b1;
        R = 19'(-3);
        repeat (2) @(negedge CLK);
        check("reset_busy", int'(BUSY), 0);
        check("reset_done", int'(DONE), 0);
        check("reset_found", int'(FOUND), 0);
        check("reset_x", int'(X), 0);
`ifdef ROOT_COUNT_EN
        check("reset_nroots", int'(NROOTS), 0);
`endif
        RST = 1'b0;
        START = 1'b0;
        $display("reset checked");

`ifdef ROOT_COUNT_EN
        run_search(4, 1'b0, 0);
        run_search(0, 1'b0, 0);
        run_search(3, 1'b0, 0);
        run_search(49, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            int xv;
            xv = int'($urandom_range(0, 15)) - 8;
            run_search(p_of(xv), 1'b0, 0);
        end
`else
        run_search(-3, 1'b0, 0);
        run_search(-1249, 1'b0, 0);
        run_search(581, 1'b0, 0);
        run_search(7, 1'b0, 0);
        run_search(0, 1'b0, 0);
        run_search(-3, 1'b1, 49);
        run_search(49, 1'b0, 0);
        abort_search(-3);
        run_search(49, 1'b0, 0);
        for (int i = 0; i < 16; i++) begin
            int rv;
            if ($urandom_range(0, 2) != 0)
                rv = p_of(int'($urandom_range(0, 15)) - 8);
            else
                rv = int'($urandom_range(0, 4000)) - 2000;
            run_search(rv, 1'b0, 0);
        end
`endif

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/poly_root_search.md
Name: poly_root_search

Overview:
- Inverse of the cubic-evaluator datapath. The evaluator maps a signed 4-bit X to a signed 19-bit R; this block takes a signed 19-bit target R and finds the X in [-8, 7] for which P(X) == R.
- P(X) = A3*X^3 + A2*X^2 + A1*X + A0. Coefficients are parameters.
- The block scans candidates sequentially, evaluating each by Horner's rule on one shared multiply-add.
- It sits downstream of the evaluator and serves as a round-trip checker and decoder.

Parameters:
- A3, 2, signed 8-bit cubic coefficient
- A2, -3, signed 8-bit quadratic coefficient
- A1, 5, signed 8-bit linear coefficient
- A0, 7, signed 8-bit constant term

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous reset, active-high
- START  input  1  request a search; sampled only in IDLE
- R  input  19  signed target value; captured on the accepted START edge
- BUSY  output  1  high while in EVAL or CHECK
- DONE  output  1  one-cycle pulse when the search ends
- FOUND  output  1  a match exists; valid from DONE until the next accepted START
- X  output  4  signed root; valid when FOUND=1, otherwise 0

Behaviour:
- Reset: when RST is high at an edge, the block enters IDLE and clears BUSY, DONE, FOUND, X, the candidate register and the accumulator. RST has priority over START. RST mid-search aborts the search; no DONE is issued for it.
- All outputs are registered.
- Internal state:
  - R_reg: 19 bits.
  - cand: signed 4-bit candidate.
  - acc: signed 24-bit accumulator. It is wide enough for |P(X)| <= 128*(512+64+8+1) = 74880, so no overflow occurs.
  - step: 2 bits.
- States: IDLE, EVAL, CHECK, DONE.
- IDLE: when START=1, capture R, set cand=-8, acc=sext(A3), step=0, go to EVAL, BUSY=1. If START=0, stay in IDLE.
- EVAL: each cycle computes acc <= acc*cand + sext(next coef), using A2, A1, A0 in order. step counts 0..2. After the step=2 update, go to CHECK. This takes exactly 3 cycles.
- CHECK: compare acc with sext(R_reg) to 24 bits.
  - Match: latch X=cand, FOUND=1, go to DONE.
  - No match and cand==7: FOUND=0, X=0, go to DONE. cand does not wrap.
  - Otherwise: cand <= cand+1, acc <= sext(A3), step=0, go to EVAL.
- DONE: DONE=1 and BUSY=0 for exactly one cycle, then IDLE. FOUND and X hold until the next accepted START; that START clears FOUND and X on the same edge.
- Timing:
  - Each candidate costs 4 cycles.
  - Candidate index i = cand+8. With START accepted at edge k, DONE is high in the cycle after edge k+4*(i+1).
  - Worst case (no match) is 64 cycles after the accepted START.
- START while BUSY or in DONE is ignored. R changes after capture have no effect.
- START held high continuously restarts a new search on each IDLE cycle.
- The first (most negative) matching candidate wins. Scanning stops at the first match.

Optional Feature:
- Macro: ROOT_COUNT_EN.
- Defined:
  - Adds output NROOTS, 5 bits unsigned, range 0..16, reset 0.
  - CHECK never exits early; all 16 candidates are always scanned.
  - X/FOUND latch only the first match.
  - NROOTS counts the matches and is updated in the same cycle DONE rises.
  - DONE is always in the cycle after edge k+64.
- Undefined: no NROOTS port; early exit as described above.

Test Plan:
- Reset: RST=1 for 2 cycles with START=1 -> BUSY=0, DONE=0, FOUND=0, X=0; START ignored while RST is high.
- Default coefficients, R=-3 (P(-1)=-3), START at edge k -> DONE in the cycle after edge k+32, FOUND=1, X=-1 (4'b1111).
- Boundaries: R=-1249 -> X=-8, DONE after edge k+4. R=581 -> X=7, DONE after edge k+64. R=7 -> X=0.
- No root: R=0 (P is strictly increasing, no integer root) -> DONE after edge k+64, FOUND=0, X=0.
- START pulsed mid-search and R changed to 49 -> ignored; the original result stands. A new START with R=49 afterwards -> X=3.
- RST asserted at cycle k+10 of a search for R=-3 -> no DONE pulse. Next START with R=49 -> X=3.
- With ROOT_COUNT_EN and A3=0, A2=1, A1=0, A0=0 (P=X^2), R=4 -> X=-2, FOUND=1, NROOTS=2, DONE after edge k+64. R=0 -> X=0, NROOTS=1.
